gray_counter_n: RTL and testbench

GRAY_COUNTER_N -- requirements
Module: gray_counter_n

---
 rtl/gray_counter_n.sv | 132 +++++++++++++
 tb/tb_gray_counter_n.sv | 131 +++++++++++++
 2 files changed

// File: rtl/gray_counter_n.sv
// gray_counter_n
//   Up/down Gray-code counter. The count lives in binary (bin_q) and the Gray
//   output is registered alongside it, so Output is glitch-free and adjacent
//   values differ in exactly one bit. Boundary events (up step from all-ones,
//   down step from zero) set sticky Overflow/Underflow flags and pulse Wrap.
//
//   Configuration:
//     GRAY_SATURATE_EN  defined   -> counter holds at the boundary instead of
//                                    wrapping (flags and Wrap still fire).
//                       undefined -> counter wraps modulo 2^WIDTH.
//
//   Parameters:
//     WIDTH  counter width in bits (2..16)
//     INIT   binary count loaded at reset and at power-up
//
//   Ports:
//     Clk        in   clock, rising edge
//     Reset      in   synchronous, active-high reset
//     En         in   count enable
//     Dir        in   1 = up, 0 = down
//     Load       in   load strobe (beats En)
//     LoadVal    in   Gray-coded load value
//     ClrFlag    in   clear sticky flags (a same-edge boundary event wins)
//     Output     out  registered Gray count
//     Binary     out  combinational binary decode of Output
//     Overflow   out  sticky top-event flag
//     Underflow  out  sticky bottom-event flag
//     Wrap       out  one-cycle pulse on a boundary event
module gray_counter_n #(
  parameter int WIDTH = 3,
  parameter int INIT  = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             ClrFlag,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Binary,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Wrap
);

  localparam logic [WIDTH-1:0] BIN_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] INIT_BIN = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] INIT_GRY = INIT_BIN ^ (INIT_BIN >> 1);

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Declaration initialisers give the post-reset values at power-up.
  logic [WIDTH-1:0] bin_q  = INIT_BIN;
  logic [WIDTH-1:0] gray_q = INIT_GRY;
  logic             ovf_q  = 1'b0;
  logic             unf_q  = 1'b0;
  logic             wrap_q = 1'b0;

  logic [WIDTH-1:0] bin_d;
  logic             ovf_d, unf_d, wrap_d;

  always_comb begin
    bin_d  = bin_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    wrap_d = 1'b0;
    // Clear first so a boundary event below can re-set its own flag.
    if (ClrFlag) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (Load) begin
      bin_d = gray2bin(LoadVal);
    end else if (En) begin
      if (Dir) begin
        if (bin_q == BIN_MAX) begin
          ovf_d  = 1'b1;
          wrap_d = 1'b1;
`ifdef GRAY_SATURATE_EN
          bin_d  = BIN_MAX;
`else
          bin_d  = '0;
`endif
        end else begin
          bin_d = bin_q + 1'b1;
        end
      end else begin
        if (bin_q == '0) begin
          unf_d  = 1'b1;
          wrap_d = 1'b1;
`ifdef GRAY_SATURATE_EN
          bin_d  = '0;
`else
          bin_d  = BIN_MAX;
`endif
        end else begin
          bin_d = bin_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bin_q  <= INIT_BIN;
      gray_q <= INIT_GRY;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= bin_d ^ (bin_d >> 1);
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      wrap_q <= wrap_d;
    end
  end

  assign Output    = gray_q;
  assign Binary    = gray2bin(gray_q);
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;
  assign Wrap      = wrap_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// Directed bench for gray_counter_n (WIDTH=3). A second instance with INIT=5
// shares the stimulus to check the reset value of a non-zero INIT.
module tb_gray_counter_n;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0, En = 1'b0, Dir = 1'b0, Load = 1'b0, ClrFlag = 1'b0;
  logic [2:0] LoadVal = 3'b000;
  logic [2:0] gout, gbin, gout5, gbin5;
  logic       govf, gunf, gwrap, govf5, gunf5, gwrap5;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  gray_counter_n #(.WIDTH(3), .INIT(0)) u_dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Dir(Dir), .Load(Load),
    .LoadVal(LoadVal), .ClrFlag(ClrFlag), .Output(gout), .Binary(gbin),
    .Overflow(govf), .Underflow(gunf), .Wrap(gwrap)
  );

  gray_counter_n #(.WIDTH(3), .INIT(5)) u_dut5 (
    .Clk(Clk), .Reset(Reset), .En(En), .Dir(Dir), .Load(Load),
    .LoadVal(LoadVal), .ClrFlag(ClrFlag), .Output(gout5), .Binary(gbin5),
    .Overflow(govf5), .Underflow(gunf5), .Wrap(gwrap5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle;
    Reset = 0; En = 0; Dir = 0; Load = 0; ClrFlag = 0; LoadVal = 3'b000;
  endtask

  // Expected Gray sequence counting up from 0 (one entry per edge).
  logic [2:0] up_seq [8] = '{3'b001, 3'b011, 3'b010, 3'b110,
                             3'b111, 3'b101, 3'b100, 3'b000};

  initial begin
    logic [2:0] e;
    // Power-up values equal the reset values.
    #1;
    chk("pwrup_out",  {29'd0, gout}, 32'd0);
    chk("pwrup_flag", {29'd0, govf, gunf, gwrap}, 32'd0);
    chk("pwrup_out5", {29'd0, gout5}, 32'b111);

    // Reset, then 8 up steps.
    Reset = 1; step; idle;
    chk("rst_out", {29'd0, gout}, 32'd0);
    En = 1; Dir = 1;
    for (int i = 0; i < 8; i++) begin
      step;
      e = up_seq[i];
`ifdef GRAY_SATURATE_EN
      if (i == 7) e = 3'b100;
`endif
      chk($sformatf("up_out%0d", i), {29'd0, gout}, {29'd0, e});
      chk($sformatf("up_ovf%0d", i), {31'd0, govf}, (i == 7) ? 32'd1 : 32'd0);
      chk($sformatf("up_wrap%0d", i), {31'd0, gwrap}, (i == 7) ? 32'd1 : 32'd0);
    end

    // Reset, one down step from zero -> bottom event.
    idle; Reset = 1; step; idle;
    chk("rst_ovf", {31'd0, govf}, 32'd0);
    En = 1; Dir = 0; step;
`ifdef GRAY_SATURATE_EN
    chk("dn_out", {29'd0, gout}, 32'b000);
    chk("dn_bin", {29'd0, gbin}, 32'b000);
`else
    chk("dn_out", {29'd0, gout}, 32'b100);
    chk("dn_bin", {29'd0, gbin}, 32'b111);
`endif
    chk("dn_unf",  {31'd0, gunf}, 32'd1);
    chk("dn_wrap", {31'd0, gwrap}, 32'd1);
    idle; step;
    chk("hold_wrap", {31'd0, gwrap}, 32'd0);
    chk("hold_unf",  {31'd0, gunf}, 32'd1);

    // Load beats En, flags unchanged, Wrap stays low.
    Load = 1; En = 1; Dir = 1; LoadVal = 3'b110; step; idle;
    chk("ld_out",  {29'd0, gout}, 32'b110);
    chk("ld_bin",  {29'd0, gbin}, 32'b100);
    chk("ld_unf",  {31'd0, gunf}, 32'd1);
    chk("ld_wrap", {31'd0, gwrap}, 32'd0);
    // Down step mid-range: bin 4 -> 3 (Gray 010).
    En = 1; Dir = 0; step; idle;
    chk("mid_dn", {29'd0, gout}, 32'b010);
    ClrFlag = 1; step; idle;
    chk("clr_flags", {30'd0, govf, gunf}, 32'd0);

    // Set wins over ClrFlag; the other flag clears.
    En = 1; Dir = 0; Load = 1; LoadVal = 3'b000; step; idle;  // load 0
    En = 1; Dir = 0; step; idle;                               // underflow
    chk("pre_unf", {31'd0, gunf}, 32'd1);
    Load = 1; LoadVal = 3'b100; step; idle;
    En = 1; Dir = 1; ClrFlag = 1; step; idle;
`ifdef GRAY_SATURATE_EN
    chk("setwin_out", {29'd0, gout}, 32'b100);
`else
    chk("setwin_out", {29'd0, gout}, 32'b000);
`endif
    chk("setwin_ovf",  {31'd0, govf}, 32'd1);
    chk("setwin_unf",  {31'd0, gunf}, 32'd0);
    chk("setwin_wrap", {31'd0, gwrap}, 32'd1);

    // Reset overrides Load/En mid-count.
    Load = 1; LoadVal = 3'b111; step; idle;
    chk("mid_out", {29'd0, gout}, 32'b111);
    Reset = 1; Load = 1; LoadVal = 3'b010; En = 1; Dir = 1; ClrFlag = 1; step; idle;
    chk("ovr_out",  {29'd0, gout}, 32'd0);
    chk("ovr_flag", {29'd0, govf, gunf, gwrap}, 32'd0);
    chk("ovr_out5", {29'd0, gout5}, 32'b111);
    chk("ovr_bin5", {29'd0, gbin5}, 32'b101);
    chk("ovr_flag5", {29'd0, govf5, gunf5, gwrap5}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
